ras_stack: RTL and testbench

- Return-address stack; the consumer end of the jump-decode signals.
- Link-saving jumps (jal/jalr) push their return address. Register-indirect returns (jr/jalr through $ra) pop.
- Sits beside the ID stage and supplies a predicted return target to fetch.
- Holds a speculative pointer updated at decode and a committed pointer updated at writeback; flush restores speculative from committed.

---
 rtl/ras_stack_pkg.sv | 18 +
 rtl/ras_ptr.sv | 59 +++++
 rtl/ras_stack.sv | 132 +++++++++++++
 tb/tb_ras_stack.sv | 204 ++++++++++++++++++++
 4 files changed

// File: rtl/ras_stack_pkg.sv
// Shared constants and types for the return-address stack.
// RAS_DEPTH_DEF / RAS_AW_DEF are the default depth and address width.
// REG_RA is the link register index used by decode for return detection.
package ras_stack_pkg;

    localparam int unsigned RAS_DEPTH_DEF = 8;
    localparam int unsigned RAS_AW_DEF    = 32;
    localparam logic [4:0]  REG_RA        = 5'd31;

    // Decoded stack operation for one cycle.
    typedef enum logic [1:0] {
        OpNone,
        OpPush,
        OpPop,
        OpReplace
    } ras_op_e;

endpackage

// File: rtl/ras_ptr.sv
// Pointer/count next-state logic for one copy of the return-address stack.
// Purely combinational; used once for the speculative copy and once for the
// committed copy. The write index for a push is always ptr_nxt.
module ras_ptr
    import ras_stack_pkg::*;
#(
    parameter int unsigned DEPTH = RAS_DEPTH_DEF,
    parameter int unsigned PTR_W = $clog2(DEPTH)
) (
    input  logic             push,
    input  logic             pop,
    input  logic [PTR_W-1:0] ptr,
    input  logic [PTR_W:0]   count,
    output logic [PTR_W-1:0] ptr_nxt,
    output logic [PTR_W:0]   count_nxt
);

    localparam int unsigned CNT_W = PTR_W + 1;

    logic    empty;
    logic    full;
    ras_op_e op;

    // Classify the request; push+pop on an empty stack degrades to a plain push.
    always_comb begin
        empty = (count == '0);
        full  = (count == CNT_W'(DEPTH));
        if (push && pop && !empty) begin
            op = OpReplace;
        end else if (push) begin
            op = OpPush;
        end else if (pop && !empty) begin
            op = OpPop;
        end else begin
            op = OpNone;
        end
    end

    // Apply the operation; a push when full wraps onto the oldest entry.
    always_comb begin
        ptr_nxt   = ptr;
        count_nxt = count;
        unique case (op)
            OpPush: begin
                ptr_nxt = ptr + PTR_W'(1);
                if (!full) begin
                    count_nxt = count + CNT_W'(1);
                end
            end
            OpPop: begin
                ptr_nxt   = ptr - PTR_W'(1);
                count_nxt = count - CNT_W'(1);
            end
            default: begin
            end
        endcase
    end

endmodule

// File: rtl/ras_stack.sv
// Return-address stack beside ID. Speculative pointer moves at decode, the
// committed pointer moves at writeback, and flush copies committed into
// speculative. Entry storage is shared and never repaired after a flush.
// Optional statistics counters are enabled with `define RAS_STATS_EN.
module ras_stack
    import ras_stack_pkg::*;
#(
    parameter int unsigned DEPTH = RAS_DEPTH_DEF,
    parameter int unsigned PTR_W = $clog2(DEPTH),
    parameter int unsigned AW    = RAS_AW_DEF
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          stall,
    input  logic          flush,
    input  logic          id_push,
    input  logic [AW-1:0] id_push_addr,
    input  logic          id_pop,
    input  logic          wb_push,
    input  logic          wb_pop,
    output logic          pred_valid,
    output logic [AW-1:0] pred_addr,
    output logic [31:0]   stat_push,
    output logic [31:0]   stat_ovf,
    output logic [31:0]   stat_udf
);

    localparam int unsigned CNT_W = PTR_W + 1;

    logic [AW-1:0]    mem [DEPTH];
    logic [PTR_W-1:0] spec_ptr, spec_ptr_nxt, cmt_ptr, cmt_ptr_nxt;
    logic [CNT_W-1:0] spec_count, spec_count_nxt, cmt_count, cmt_count_nxt;
    logic             spec_push, spec_pop;

    assign spec_push = id_push && !stall && !flush;
    assign spec_pop  = id_pop && !stall && !flush;

    ras_ptr #(
        .DEPTH (DEPTH),
        .PTR_W (PTR_W)
    ) u_spec_ptr (
        .push      (spec_push),
        .pop       (spec_pop),
        .ptr       (spec_ptr),
        .count     (spec_count),
        .ptr_nxt   (spec_ptr_nxt),
        .count_nxt (spec_count_nxt)
    );

    ras_ptr #(
        .DEPTH (DEPTH),
        .PTR_W (PTR_W)
    ) u_cmt_ptr (
        .push      (wb_push),
        .pop       (wb_pop),
        .ptr       (cmt_ptr),
        .count     (cmt_count),
        .ptr_nxt   (cmt_ptr_nxt),
        .count_nxt (cmt_count_nxt)
    );

    // Entry storage: a push (or in-place replace) writes at the new top index.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < int'(DEPTH); i++) begin
                mem[i] <= '0;
            end
        end else if (spec_push) begin
            mem[spec_ptr_nxt] <= id_push_addr;
        end
    end

    // Speculative copy; flush takes the committed next state, same-cycle wb included.
    always_ff @(posedge clk) begin
        if (rst) begin
            spec_ptr   <= '0;
            spec_count <= '0;
        end else if (flush) begin
            spec_ptr   <= cmt_ptr_nxt;
            spec_count <= cmt_count_nxt;
        end else begin
            spec_ptr   <= spec_ptr_nxt;
            spec_count <= spec_count_nxt;
        end
    end

    // Committed copy tracks writeback only.
    always_ff @(posedge clk) begin
        if (rst) begin
            cmt_ptr   <= '0;
            cmt_count <= '0;
        end else begin
            cmt_ptr   <= cmt_ptr_nxt;
            cmt_count <= cmt_count_nxt;
        end
    end

    assign pred_valid = (spec_count != '0);
    assign pred_addr  = mem[spec_ptr];

`ifdef RAS_STATS_EN
    logic [31:0] push_cnt, ovf_cnt, udf_cnt;

    // Committed push/overflow/underflow event counters, wrapping at 2^32.
    always_ff @(posedge clk) begin
        if (rst) begin
            push_cnt <= '0;
            ovf_cnt  <= '0;
            udf_cnt  <= '0;
        end else begin
            if (wb_push) begin
                push_cnt <= push_cnt + 32'd1;
            end
            if (wb_push && !wb_pop && (cmt_count == CNT_W'(DEPTH))) begin
                ovf_cnt <= ovf_cnt + 32'd1;
            end
            if (wb_pop && !wb_push && (cmt_count == '0)) begin
                udf_cnt <= udf_cnt + 32'd1;
            end
        end
    end

    assign stat_push = push_cnt;
    assign stat_ovf  = ovf_cnt;
    assign stat_udf  = udf_cnt;
`else
    assign stat_push = '0;
    assign stat_ovf  = '0;
    assign stat_udf  = '0;
`endif

endmodule

// File: tb/tb_ras_stack.sv
// Bench for ras_stack: directed scenarios then random traffic, all checked
// against a behavioural model of the stack kept with integer arithmetic.
module tb_ras_stack;

    localparam int D = 8;

    logic        clk;
    logic        rst;
    logic        stall;
    logic        flush;
    logic        id_push;
    logic [31:0] id_push_addr;
    logic        id_pop;
    logic        wb_push;
    logic        wb_pop;
    logic        pred_valid;
    logic [31:0] pred_addr;
    logic [31:0] stat_push;
    logic [31:0] stat_ovf;
    logic [31:0] stat_udf;

    int total = 0;
    int bad   = 0;

    // Reference model state
    logic [31:0] m_mem [D];
    int          m_sp, m_sc, m_cp, m_cc;
    logic [31:0] m_spush, m_sovf, m_sudf;

    ras_stack dut (
        .clk          (clk),
        .rst          (rst),
        .stall        (stall),
        .flush        (flush),
        .id_push      (id_push),
        .id_push_addr (id_push_addr),
        .id_pop       (id_pop),
        .wb_push      (wb_push),
        .wb_pop       (wb_pop),
        .pred_valid   (pred_valid),
        .pred_addr    (pred_addr),
        .stat_push    (stat_push),
        .stat_ovf     (stat_ovf),
        .stat_udf     (stat_udf)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: got %h want %h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < D; i++) m_mem[i] = '0;
        m_sp = 0; m_sc = 0; m_cp = 0; m_cc = 0;
        m_spush = '0; m_sovf = '0; m_sudf = '0;
    endtask

    task automatic model_step(input logic r, input logic f, input logic s, input logic ip,
                              input logic [31:0] a, input logic io, input logic wp,
                              input logic wo);
        int ncp, ncc;
        if (r) begin
            model_reset();
            return;
        end
        ncp = m_cp;
        ncc = m_cc;
        if (wp && !(wo && m_cc > 0)) begin
            ncp = (m_cp + 1) % D;
            ncc = (m_cc < D) ? m_cc + 1 : D;
        end else if (wo && !wp && m_cc > 0) begin
            ncp = (m_cp + D - 1) % D;
            ncc = m_cc - 1;
        end
        if (wp) m_spush = m_spush + 1;
        if (wp && !wo && m_cc == D) m_sovf = m_sovf + 1;
        if (wo && !wp && m_cc == 0) m_sudf = m_sudf + 1;
        if (f) begin
            m_sp = ncp;
            m_sc = ncc;
        end else if (!s) begin
            if (ip && io && m_sc > 0) begin
                m_mem[m_sp] = a;
            end else if (ip) begin
                m_sp = (m_sp + 1) % D;
                m_mem[m_sp] = a;
                if (m_sc < D) m_sc++;
            end else if (io && m_sc > 0) begin
                m_sp = (m_sp + D - 1) % D;
                m_sc--;
            end
        end
        m_cp = ncp;
        m_cc = ncc;
    endtask

    task automatic check_all(input string tag);
        chk({tag, ".valid"}, {31'd0, pred_valid}, (m_sc != 0) ? 32'd1 : 32'd0);
        chk({tag, ".addr"}, pred_addr, m_mem[m_sp]);
`ifdef RAS_STATS_EN
        chk({tag, ".spush"}, stat_push, m_spush);
        chk({tag, ".sovf"}, stat_ovf, m_sovf);
        chk({tag, ".sudf"}, stat_udf, m_sudf);
`else
        chk({tag, ".spush"}, stat_push, 32'd0);
        chk({tag, ".sovf"}, stat_ovf, 32'd0);
        chk({tag, ".sudf"}, stat_udf, 32'd0);
`endif
    endtask

    task automatic cyc(input string tag, input logic r, input logic f, input logic s,
                       input logic ip, input logic [31:0] a, input logic io,
                       input logic wp, input logic wo);
        rst = r; flush = f; stall = s; id_push = ip; id_push_addr = a;
        id_pop = io; wb_push = wp; wb_pop = wo;
        @(posedge clk);
        model_step(r, f, s, ip, a, io, wp, wo);
        #1;
        check_all(tag);
    endtask

    initial begin
        model_reset();
        rst = 1'b0; flush = 1'b0; stall = 1'b0; id_push = 1'b0; id_push_addr = '0;
        id_pop = 1'b0; wb_push = 1'b0; wb_pop = 1'b0;

        // Reset state
        cyc("reset", 1, 0, 0, 0, 0, 0, 0, 0);
        chk("reset_valid", {31'd0, pred_valid}, 32'd0);
        chk("reset_addr", pred_addr, 32'd0);

        // Three pushes then one pop
        cyc("p100", 0, 0, 0, 1, 32'h100, 0, 0, 0);
        cyc("p200", 0, 0, 0, 1, 32'h200, 0, 0, 0);
        cyc("p300", 0, 0, 0, 1, 32'h300, 0, 0, 0);
        chk("top300", pred_addr, 32'h300);
        chk("valid3", {31'd0, pred_valid}, 32'd1);
        cyc("pop1", 0, 0, 0, 0, 0, 1, 0, 0);
        chk("top200", pred_addr, 32'h200);

        // Overflow: nine pushes, eight pops
        cyc("rst2", 1, 0, 0, 0, 0, 0, 0, 0);
        for (int i = 1; i <= 9; i++) cyc("ovf_push", 0, 0, 0, 1, 32'(i), 0, 0, 0);
        for (int i = 1; i <= 8; i++) begin
            chk("ovf_top", pred_addr, 32'(10 - i));
            cyc("ovf_pop", 0, 0, 0, 0, 0, 1, 0, 0);
        end
        chk("ovf_empty", {31'd0, pred_valid}, 32'd0);

        // Underflow on both copies
        cyc("udf", 0, 0, 0, 0, 0, 1, 0, 1);
        chk("udf_valid", {31'd0, pred_valid}, 32'd0);
`ifdef RAS_STATS_EN
        chk("udf_stat", stat_udf, 32'd1);
`endif

        // Same-cycle push+pop replaces the top
        cyc("rst3", 1, 0, 0, 0, 0, 0, 0, 0);
        cyc("pA0", 0, 0, 0, 1, 32'hA0, 0, 0, 0);
        cyc("repB0", 0, 0, 0, 1, 32'hB0, 1, 0, 0);
        chk("rep_top", pred_addr, 32'hB0);
        cyc("rep_pop", 0, 0, 0, 0, 0, 1, 0, 0);
        chk("rep_empty", {31'd0, pred_valid}, 32'd0);

        // Flush restores speculative from committed
        cyc("rst4", 1, 0, 0, 0, 0, 0, 0, 0);
        cyc("s40", 0, 0, 0, 1, 32'h40, 0, 0, 0);
        cyc("s50w", 0, 0, 0, 1, 32'h50, 0, 1, 0);
        cyc("s60", 0, 0, 0, 1, 32'h60, 0, 0, 0);
        cyc("flush", 0, 1, 0, 0, 0, 0, 0, 0);
        chk("flush_addr", pred_addr, 32'h40);
        chk("flush_valid", {31'd0, pred_valid}, 32'd1);

        // Stall blocks pushes; rst beats flush
        cyc("stall", 0, 0, 1, 1, 32'h77, 0, 0, 0);
        chk("stall_addr", pred_addr, 32'h40);
        cyc("rstflush", 1, 1, 0, 0, 0, 0, 0, 0);
        chk("rf_valid", {31'd0, pred_valid}, 32'd0);
        chk("rf_addr", pred_addr, 32'd0);

        // Random traffic
        for (int n = 0; n < 600; n++) begin
            cyc("rand",
                ($urandom_range(63) == 0),
                ($urandom_range(15) == 0),
                ($urandom_range(7) == 0),
                ($urandom_range(1) == 0),
                $urandom,
                ($urandom_range(2) == 0),
                ($urandom_range(1) == 0),
                ($urandom_range(2) == 0));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
